// File: rtl/switch_debouncer.sv
// switch_debouncer
// Two-flop synchroniser plus an independent debounce counter per switch line.
// A line's debounced level only changes after its synchronised input has held
// the new level for DEBOUNCE_CYCLES consecutive cycles. Each accepted change
// raises a one-cycle rise or fall pulse. A rising change also flips that line's
// toggle bit, so LED logic can use the toggle output directly.
module switch_debouncer #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 10
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_switch,
  output logic [N-1:0] o_switch,
  output logic [N-1:0] o_rise,
  output logic [N-1:0] o_fall,
  output logic [N-1:0] o_toggle
);

  // The counter must reach DEBOUNCE_CYCLES-1. For DEBOUNCE_CYCLES >= 2,
  // $clog2(DEBOUNCE_CYCLES) bits are always enough.
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]  sync1;
  logic [N-1:0]  sync2;
  logic [CW-1:0] cnt [N];

  // Bring the asynchronous switch pins into the clock domain. Only sync2 is
  // used downstream.
  always_ff @(posedge i_clk) begin
    // NOTE: use non-blocking assignments for registers. Every flop then samples
    // its pre-edge value, so sync2 takes the old sync1 and not the one being
    // written on this same edge.
    if (!i_rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= i_switch;
      sync2 <= sync1;
    end
  end

  // Per-line debounce. Any cycle that agrees with the current level restarts
  // the count. Reaching CNT_MAX commits the new level and emits the edge
  // pulses.
  always_ff @(posedge i_clk) begin
    // NOTE: the counter array is cleared element by element in reset. A pending
    // count must not survive a reset, so the array cannot stay uninitialised
    // like a RAM.
    if (!i_rst_n) begin
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
      o_switch <= '0;
      o_rise   <= '0;
      o_fall   <= '0;
      o_toggle <= '0;
    end else begin
      o_rise <= '0;
      o_fall <= '0;
      for (int i = 0; i < N; i++) begin
        if (sync2[i] == o_switch[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          cnt[i]      <= '0;
          o_switch[i] <= sync2[i];
          o_rise[i]   <= sync2[i];
          o_fall[i]   <= ~sync2[i];
          if (sync2[i]) begin
            o_toggle[i] <= ~o_toggle[i];
          end
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule
